// File: rtl/dvi_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : dvi_ctrl_pkg                                               |
// | Description : Shared state encoding and TMDS lane tokens for the DVI     |
// |               lane sequencer and its lock filter.                        |
// |               CLK_WORD : five ones then five zeros, one pixel-clock      |
// |                          period on the TMDS clock lane.                  |
// |               BLANK    : control token for C1C0 = 00.                    |
// |               TP_A/TP_B: alternating DC-balanced eye-check words.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package dvi_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_OFF          = 3'd0,
      ST_CLK_ONLY     = 3'd1,
      ST_WAIT_FRAME   = 3'd2,
      ST_ACTIVE       = 3'd3,
      ST_DRAIN        = 3'd4,
      ST_CLK_ONLY_OUT = 3'd5
   } dvi_state_t;

   localparam logic [9:0] CLK_WORD = 10'b1111100000;
   localparam logic [9:0] BLANK    = 10'h354;
   localparam logic [9:0] TP_A     = 10'h155;
   localparam logic [9:0] TP_B     = 10'h2AA;

endpackage : dvi_ctrl_pkg
`default_nettype wire

// File: rtl/dvi_lock_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dvi_lock_filter                                            |
// | Description : Two-flop synchronizer for the PLL lock flag followed by a  |
// |               saturating run-length counter of consecutive locked        |
// |               cycles.                                                    |
// | Ports       : clk        in   pixel clock                                |
// |               reset      in   synchronous active-high reset              |
// |               pll_locked in   raw lock flag (asynchronous origin)        |
// |               lk         out  synchronized lock flag                     |
// |               lock_ok    out  lock held for LOCK_CYCLES cycles           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module dvi_lock_filter #(
   parameter int LOCK_CYCLES = 1024,
   parameter int CNT_W       = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic pll_locked,
   output logic lk,
   output logic lock_ok
);

   localparam logic [CNT_W-1:0] c_lock_max = CNT_W'(LOCK_CYCLES);
   localparam logic [CNT_W-1:0] c_one      = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             r_sync1;
   logic             r_sync2;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= pll_locked;
         r_sync2 <= r_sync1;
         // Any single unlocked cycle restarts the qualification window.
         if (!r_sync2) begin
            r_cnt <= '0;
         end else if (r_cnt != c_lock_max) begin
            r_cnt <= r_cnt + c_one;
         end
      end
   end

   assign lk      = r_sync2;
   assign lock_ok = (r_cnt == c_lock_max);

endmodule : dvi_lock_filter
`default_nettype wire

// File: rtl/dvi_lane_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dvi_lane_sequencer                                         |
// | Description : Pixel-clock sequencer for a 4-lane TMDS serializer:        |
// |               PLL-lock qualification, clock-lane-only training,          |
// |               vsync-aligned video start and vsync-aligned shutdown.      |
// |               All outputs are registered; pass-through latency is one    |
// |               cycle.                                                     |
// | Ports       : clk, reset            clock / sync active-high reset       |
// |               pll_locked            raw clkx5 PLL lock flag              |
// |               enable                software video request               |
// |               vsync_in              vsync aligned with tmds_in_*         |
// |               test_mode             (DVI_TEST_PATTERN_EN only)           |
// |               tmds_in_0..2          B/G/R encoder words                  |
// |               tmds_out_0..2         serializer data lanes                |
// |               tmds_out_3            serializer clock lane                |
// |               state, video_active   status                               |
// | Macro       : DVI_TEST_PATTERN_EN adds test_mode and the eye-check       |
// |               pattern generator on the data lanes.                       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module dvi_lane_sequencer
   import dvi_ctrl_pkg::*;
#(
   parameter int LOCK_CYCLES     = 1024,
   parameter int CLK_ONLY_CYCLES = 4096,
   parameter int CNT_W           = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pll_locked,
   input  logic       enable,
   input  logic       vsync_in,
`ifdef DVI_TEST_PATTERN_EN
   input  logic       test_mode,
`endif
   input  logic [9:0] tmds_in_0,
   input  logic [9:0] tmds_in_1,
   input  logic [9:0] tmds_in_2,
   output logic [9:0] tmds_out_0,
   output logic [9:0] tmds_out_1,
   output logic [9:0] tmds_out_2,
   output logic [9:0] tmds_out_3,
   output logic [2:0] state,
   output logic       video_active
);

   localparam logic [CNT_W-1:0] c_train_last = CNT_W'(CLK_ONLY_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_one        = {{(CNT_W-1){1'b0}}, 1'b1};

   dvi_state_t       r_state;
   dvi_state_t       w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             r_vsync_q;
   logic [9:0]       r_out_0;
   logic [9:0]       r_out_1;
   logic [9:0]       r_out_2;
   logic [9:0]       r_out_3;
   logic             r_video_active;

   logic             w_lk;
   logic             w_lock_ok;
   logic             w_vs_rise;
   logic             w_train_done;
   logic [9:0]       w_data_0;
   logic [9:0]       w_data_1;
   logic [9:0]       w_data_2;

   dvi_lock_filter #(
      .LOCK_CYCLES (LOCK_CYCLES),
      .CNT_W       (CNT_W)
   ) u_lock_filter (
      .clk        (clk),
      .reset      (reset),
      .pll_locked (pll_locked),
      .lk         (w_lk),
      .lock_ok    (w_lock_ok)
   );

   assign w_vs_rise    = vsync_in & ~r_vsync_q;
   assign w_train_done = (r_cnt == c_train_last);

`ifdef DVI_TEST_PATTERN_EN
   logic       r_tp_phase;
   logic [9:0] w_tp_word;

   assign w_tp_word = r_tp_phase ? TP_B : TP_A;
   assign w_data_0  = test_mode ? w_tp_word : tmds_in_0;
   assign w_data_1  = test_mode ? w_tp_word : tmds_in_1;
   assign w_data_2  = test_mode ? w_tp_word : tmds_in_2;

   // Phase advances only on cycles that actually emit the pattern, so the
   // first pattern word after test_mode rises is always TP_A.
   always_ff @(posedge clk) begin
      if (reset || !test_mode) begin
         r_tp_phase <= 1'b0;
      end else if (w_next == ST_ACTIVE || w_next == ST_DRAIN) begin
         r_tp_phase <= ~r_tp_phase;
      end
   end
`else
   assign w_data_0 = tmds_in_0;
   assign w_data_1 = tmds_in_1;
   assign w_data_2 = tmds_in_2;
`endif

   // Next-state decision. Loss of synchronized lock overrides everything.
   always_comb begin
      w_next = r_state;
      if (!w_lk) begin
         w_next = ST_OFF;
      end else begin
         case (r_state)
            ST_OFF: begin
               if (w_lock_ok && enable) w_next = ST_CLK_ONLY;
            end
            ST_CLK_ONLY: begin
               if (!enable)           w_next = ST_CLK_ONLY_OUT;
               else if (w_train_done) w_next = ST_WAIT_FRAME;
            end
            ST_WAIT_FRAME: begin
               // A vsync edge coinciding with enable low holds here for a
               // cycle rather than starting a frame that would be cut short.
               if (w_vs_rise) begin
                  if (enable) w_next = ST_ACTIVE;
               end else if (!enable) begin
                  w_next = ST_CLK_ONLY_OUT;
               end
            end
            ST_ACTIVE: begin
               if (!enable) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
               if (w_vs_rise) w_next = ST_CLK_ONLY_OUT;
            end
            ST_CLK_ONLY_OUT: begin
               if (enable)            w_next = ST_WAIT_FRAME;
               else if (w_train_done) w_next = ST_OFF;
            end
            default: w_next = ST_OFF;
         endcase
      end
   end

   // Outputs are decoded from the next state so they change on the same
   // edge as the state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ST_OFF;
         r_cnt          <= '0;
         r_vsync_q      <= 1'b0;
         r_out_0        <= '0;
         r_out_1        <= '0;
         r_out_2        <= '0;
         r_out_3        <= '0;
         r_video_active <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_vsync_q <= vsync_in;

         if (w_next != r_state) begin
            r_cnt <= '0;
         end else if (!w_train_done) begin
            r_cnt <= r_cnt + c_one;
         end

         case (w_next)
            ST_OFF: begin
               r_out_0 <= '0;
               r_out_1 <= '0;
               r_out_2 <= '0;
               r_out_3 <= '0;
            end
            ST_ACTIVE, ST_DRAIN: begin
               r_out_0 <= w_data_0;
               r_out_1 <= w_data_1;
               r_out_2 <= w_data_2;
               r_out_3 <= CLK_WORD;
            end
            default: begin
               r_out_0 <= BLANK;
               r_out_1 <= BLANK;
               r_out_2 <= BLANK;
               r_out_3 <= CLK_WORD;
            end
         endcase

         r_video_active <= (w_next == ST_ACTIVE);
      end
   end

   assign tmds_out_0   = r_out_0;
   assign tmds_out_1   = r_out_1;
   assign tmds_out_2   = r_out_2;
   assign tmds_out_3   = r_out_3;
   assign state        = r_state;
   assign video_active = r_video_active;

endmodule : dvi_lane_sequencer
`default_nettype wire

// File: doc/dvi_lane_sequencer.md
Name: dvi_lane_sequencer

Overview:
- Pixel-clock-domain controller that sequences the 4-lane 10:1 TMDS serializer through power-up, clock-only training, frame-aligned video start, and frame-aligned shutdown.
- Sits between the three TMDS encoders and the serializer's four 10-bit lane inputs; lane 3 is the TMDS clock lane.
- Guarantees the sink never sees a partial frame or a clock-lane glitch while the PLL generating clkx5 is unlocked.

Parameters:
- LOCK_CYCLES, 1024, consecutive cycles pll_locked must stay high before leaving OFF.
- CLK_ONLY_CYCLES, 4096, cycles of clock-lane-only training before frame wait.
- CNT_W, 16, width of internal cycle counters; must hold max(LOCK_CYCLES, CLK_ONLY_CYCLES).

Ports:
- clk  in  1  pixel clock, the serializer's word clock; clkx5 is derived from it.
- reset  in  1  synchronous, active-high reset.
- pll_locked  in  1  lock flag from the clkx5 PLL; asynchronous origin, double-registered internally.
- enable  in  1  software request for video output.
- vsync_in  in  1  vertical sync aligned with tmds_in_*, active high.
- tmds_in_0/1/2  in  10 each  encoded words from the B/G/R encoders.
- tmds_out_0/1/2  out  10 each  words to serializer data lanes.
- tmds_out_3  out  10  word to serializer clock lane.
- state  out  3  current state encoding, for status register.
- video_active  out  1  high while in ACTIVE.

Behaviour:
- Reset and synchronicity: one clock. Reset is synchronous and active-high. On reset all outputs are 0 and state = OFF. All counters, sync flops and the vsync delay register clear.
- Output registering: all outputs are registered. In ACTIVE, tmds_out_N(t+1) = tmds_in_N(t), a latency of 1 cycle.
- Tokens: CLK_WORD = 10'b1111100000. BLANK = 10'h354 (control token C1C0 = 00).
- Lock sync: pll_locked is passed through 2 flops to give lk. Lock counter increments while lk = 1, clears while lk = 0, and saturates at LOCK_CYCLES.
- VSYNC edge: vs_rise = vsync_in & ~vsync_q.
- OFF (0): outputs all 0.
  - Goes to CLK_ONLY when lock counter == LOCK_CYCLES and enable = 1.
- CLK_ONLY (1): tmds_out_3 = CLK_WORD; lanes 0..2 = BLANK. Training counter counts from 0.
  - After CLK_ONLY_CYCLES cycles, goes to WAIT_FRAME.
- WAIT_FRAME (2): outputs as in CLK_ONLY.
  - On vs_rise, goes to ACTIVE. The first passed-through word is the tmds_in value sampled in the vs_rise cycle.
- ACTIVE (3): lanes 0..2 pass through; lane 3 = CLK_WORD.
  - enable = 0 causes a transition to DRAIN.
- DRAIN (4): continues pass-through.
  - On vs_rise, goes to CLK_ONLY_OUT. The vs_rise-cycle word is replaced by BLANK.
- CLK_ONLY_OUT (5): outputs as in CLK_ONLY for CLK_ONLY_CYCLES cycles, then goes to OFF.
  - enable = 1 during CLK_ONLY_OUT goes to WAIT_FRAME instead, and the counter clears.
- Global priority: lk = 0 in any state forces OFF on the next edge, and outputs go to 0 the same edge. This overrides enable and vs_rise.
- Simultaneous events:
  - enable falling in the same cycle as vs_rise while in WAIT_FRAME: stay in WAIT_FRAME; the frame is not started.
  - enable = 0 in CLK_ONLY or WAIT_FRAME: go to CLK_ONLY_OUT.
- Counter wrap: counters never wrap; they saturate at their terminal value.
- video_active: high only in ACTIVE. It is registered, so it is aligned with the first pass-through output word.

Optional Feature:
- Macro: DVI_TEST_PATTERN_EN.
- When defined:
  - Adds input port test_mode (1 bit).
  - In ACTIVE/DRAIN with test_mode = 1, lanes 0..2 output alternating 10'h155 / 10'h2AA, starting with 10'h155 on the first such cycle. This is a DC-balanced eye-check pattern.
  - A toggle register is reset to 0 and also cleared whenever test_mode = 0.
  - test_mode is ignored in all other states.
- When undefined: no port is added, and the datapath is pure pass-through.

Decomposition:
- Package dvi_ctrl_pkg holds:
  - state encoding (OFF..CLK_ONLY_OUT, 3-bit);
  - constants CLK_WORD, BLANK, TP_A = 10'h155, TP_B = 10'h2AA.
- One sub-module, dvi_lock_filter: 2-flop synchronizer plus saturating lock counter.
  - Parameters: LOCK_CYCLES, CNT_W.
  - Output: lock_ok.

Test Plan:
- Power-up: reset 4 cycles, pll_locked = 1, enable = 1 → OFF with outputs 0 for LOCK_CYCLES+2 cycles, then CLK_ONLY with tmds_out_3 = 0x3E0 and lanes 0..2 = 0x354.
- Frame alignment: after training, drive tmds_in_0 = 0x2CC with vsync pulse at cycle T → tmds_out_0 = 0x354 through T, and 0x2CC at T+1 with video_active = 1.
- Graceful stop: in ACTIVE, drop enable mid-frame → pass-through continues until the next vs_rise; that word becomes 0x354; OFF after CLK_ONLY_CYCLES more cycles.
- Lock loss: drop pll_locked for 1 cycle in ACTIVE → OFF and outputs 0 after 3 cycles; re-lock requires a full LOCK_CYCLES again.
- Re-enable: re-assert enable during CLK_ONLY_OUT → WAIT_FRAME; ACTIVE resumes on the next vs_rise.
- With DVI_TEST_PATTERN_EN: test_mode = 1 in ACTIVE → lanes 0..2 alternate 0x155, 0x2AA, 0x155 on consecutive cycles; lane 3 stays 0x3E0.
